// File: rtl/spikeout_arbiter.sv
// Winner-take-all arbiter for output neuron spikes: a trigger opens a decision window
// and the lowest-numbered firing channel inside it is forwarded. Optional refractory: SPIKEOUT_REFRACT_EN.
module spikeout_arbiter #(
    parameter int P_NUM     = 10,
    parameter int P_WIN     = 8,
    parameter int P_REFRACT = 4,
    parameter int P_IDX_W   = $clog2(P_NUM + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_spike_in,
    input  logic [P_NUM:1]     i_spike,
    output logic [P_NUM:1]     o_spike,
    output logic [P_IDX_W-1:0] o_winner_idx,
    output logic               o_valid,
    output logic               o_timeout,
    output logic               o_busy
);

    localparam int CNT_W = $clog2(P_WIN + 1);
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(P_WIN - 1);

    localparam bit CFG_OK = (P_NUM >= 2) && (P_NUM <= 64) &&
                            (P_WIN >= 1) && (P_WIN <= 255) &&
                            (P_REFRACT >= 1) && (P_REFRACT <= 255) &&
                            (P_IDX_W >= $clog2(P_NUM + 1));

    if (!CFG_OK) begin : g_bad_cfg
        $error("spikeout_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1
`ifdef SPIKEOUT_REFRACT_EN
        ,
        REFRACT = 2'd2
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] win_cnt;

`ifdef SPIKEOUT_REFRACT_EN
    localparam int RCNT_W = $clog2(P_REFRACT + 1);
    localparam logic [RCNT_W-1:0] REF_LOAD = RCNT_W'(P_REFRACT - 1);
    logic [RCNT_W-1:0] ref_cnt;
`endif

    logic               any_spike;
    logic [P_IDX_W-1:0] win_idx;
    logic [P_NUM:1]     win_onehot;

    // Priority encoder: scanning downward lets the lowest set channel overwrite the rest.
    always_comb begin
        win_idx    = '0;
        win_onehot = '0;
        for (int k = P_NUM; k >= 1; k--) begin
            if (i_spike[k]) begin
                win_idx        = P_IDX_W'(k);
                win_onehot     = '0;
                win_onehot[k]  = 1'b1;
            end
        end
    end

    assign any_spike = |i_spike;
    assign o_busy    = (state != IDLE);

    // NOTE: all state and outputs are updated with non-blocking assignments so every
    // branch sees the pre-edge values; o_spike/o_valid/o_timeout default low each cycle
    // so they can only ever be single-cycle pulses.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            win_cnt      <= '0;
            o_spike      <= '0;
            o_winner_idx <= '0;
            o_valid      <= 1'b0;
            o_timeout    <= 1'b0;
`ifdef SPIKEOUT_REFRACT_EN
            ref_cnt      <= '0;
`endif
        end else begin
            o_spike   <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_spike_in) begin
                        state   <= ARMED;
                        win_cnt <= WIN_LOAD;
                    end
                end

                ARMED: begin
                    if (any_spike) begin
                        o_spike      <= win_onehot;
                        o_winner_idx <= win_idx;
                        o_valid      <= 1'b1;
`ifdef SPIKEOUT_REFRACT_EN
                        state        <= REFRACT;
                        ref_cnt      <= REF_LOAD;
                        win_cnt      <= '0;
`else
                        // A coincident trigger is treated as arriving in IDLE: re-arm.
                        if (i_spike_in) begin
                            state   <= ARMED;
                            win_cnt <= WIN_LOAD;
                        end else begin
                            state   <= IDLE;
                            win_cnt <= '0;
                        end
`endif
                    end else if (i_spike_in) begin
                        win_cnt <= WIN_LOAD;
                    end else if (win_cnt == '0) begin
                        o_timeout    <= 1'b1;
                        o_winner_idx <= '0;
                        state        <= IDLE;
                    end else begin
                        win_cnt <= win_cnt - CNT_W'(1);
                    end
                end

`ifdef SPIKEOUT_REFRACT_EN
                REFRACT: begin
                    if (ref_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        ref_cnt <= ref_cnt - RCNT_W'(1);
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spikeout_arbiter.sv
// Directed bench for spikeout_arbiter (P_NUM=10, P_WIN=8, P_REFRACT=4); honours SPIKEOUT_REFRACT_EN.
module tb_spikeout_arbiter;

`ifdef SPIKEOUT_REFRACT_EN
    localparam bit REF = 1'b1;
`else
    localparam bit REF = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_spike_in;
    logic [10:1] i_spike;
    logic [10:1] o_spike;
    logic [3:0]  o_winner_idx;
    logic        o_valid;
    logic        o_timeout;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    spikeout_arbiter #(
        .P_NUM    (10),
        .P_WIN    (8),
        .P_REFRACT(4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_spike_in  (i_spike_in),
        .i_spike     (i_spike),
        .o_spike     (o_spike),
        .o_winner_idx(o_winner_idx),
        .o_valid     (o_valid),
        .o_timeout   (o_timeout),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Inputs are changed 1 time unit after the edge; outputs are read there too.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_spike_in = 1'b0;
        i_spike    = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        i_rst_n    = 1'b0;
        i_spike_in = 1'b1;
        i_spike    = 10'h3ff;
        tick();
        tick();
        checks++; if (o_spike !== 10'h000) begin errors++; $display("FAIL reset_spike got=%h exp=000", o_spike); end
        checks++; if (o_winner_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", o_winner_idx); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", o_timeout); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        i_rst_n = 1'b1;
        idle(3);
    endtask

    // Trigger at 0, channel 7 at 3 -> pulse at 4.
    task automatic test_single_win();
        for (int c = 0; c < 12; c++) begin
            int cyc;
            logic [10:1] e_sp;
            i_spike_in = (c == 0);
            i_spike    = (c == 3) ? 10'h040 : 10'h000;
            tick();
            cyc  = c + 1;
            e_sp = (cyc == 4) ? 10'h040 : 10'h000;
            checks++; if (o_valid !== (cyc == 4)) begin errors++; $display("FAIL single_valid cyc=%0d got=%b", cyc, o_valid); end
            checks++; if (o_spike !== e_sp) begin errors++; $display("FAIL single_spike cyc=%0d got=%h exp=%h", cyc, o_spike, e_sp); end
            checks++; if (o_winner_idx !== ((cyc >= 4) ? 4'd7 : 4'd0)) begin errors++; $display("FAIL single_idx cyc=%0d got=%0d", cyc, o_winner_idx); end
            checks++; if (o_busy !== ((cyc <= 3) || (REF && cyc <= 7))) begin errors++; $display("FAIL single_busy cyc=%0d got=%b", cyc, o_busy); end
            checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL single_timeout cyc=%0d got=%b", cyc, o_timeout); end
        end
    endtask

    // Second event in what would be the same window must not produce another pulse.
    task automatic test_double_event();
        int n_valid = 0;
        for (int c = 0; c < 14; c++) begin
            int cyc;
            i_spike_in = (c == 0);
            i_spike    = (c == 3 || c == 7) ? 10'h080 : 10'h000;
            tick();
            cyc = c + 1;
            if (o_valid === 1'b1) n_valid++;
            checks++; if (o_valid !== (cyc == 4)) begin errors++; $display("FAIL double_valid cyc=%0d got=%b", cyc, o_valid); end
        end
        checks++; if (n_valid != 1) begin errors++; $display("FAIL double_count got=%0d exp=1", n_valid); end
        checks++; if (o_winner_idx !== 4'd8) begin errors++; $display("FAIL double_idx got=%0d exp=8", o_winner_idx); end
        idle(2);
    endtask

    // Channels 2 and 10 together: lowest index wins.
    task automatic test_priority();
        for (int c = 0; c < 10; c++) begin
            int cyc;
            i_spike_in = (c == 0);
            i_spike    = (c == 2) ? 10'h202 : 10'h000;
            tick();
            cyc = c + 1;
            if (cyc == 3) begin
                checks++; if (o_spike !== 10'h002) begin errors++; $display("FAIL prio_spike got=%h exp=002", o_spike); end
                checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL prio_valid got=%b exp=1", o_valid); end
            end
            checks++; if (o_winner_idx !== ((cyc >= 3) ? 4'd2 : 4'd8)) begin errors++; $display("FAIL prio_idx cyc=%0d got=%0d", cyc, o_winner_idx); end
        end
        idle(2);
    endtask

    task automatic test_timeout();
        for (int c = 0; c < 12; c++) begin
            int cyc;
            i_spike_in = (c == 0);
            i_spike    = '0;
            tick();
            cyc = c + 1;
            checks++; if (o_timeout !== (cyc == 9)) begin errors++; $display("FAIL to_pulse cyc=%0d got=%b", cyc, o_timeout); end
            checks++; if (o_spike !== 10'h000) begin errors++; $display("FAIL to_spike cyc=%0d got=%h exp=000", cyc, o_spike); end
            checks++; if (o_busy !== (cyc <= 8)) begin errors++; $display("FAIL to_busy cyc=%0d got=%b", cyc, o_busy); end
            checks++; if (o_winner_idx !== ((cyc >= 9) ? 4'd0 : 4'd2)) begin errors++; $display("FAIL to_idx cyc=%0d got=%0d", cyc, o_winner_idx); end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 12; c++) begin
            int cyc;
            i_rst_n    = (c != 3);
            i_spike_in = (c == 0);
            i_spike    = (c == 5) ? 10'h040 : 10'h000;
            tick();
            cyc = c + 1;
            checks++; if (o_valid !== 1'b0 || o_timeout !== 1'b0 || o_spike !== 10'h000)
                begin errors++; $display("FAIL rstmid_out cyc=%0d valid=%b timeout=%b spike=%h exp=0", cyc, o_valid, o_timeout, o_spike); end
            checks++; if (o_busy !== (cyc <= 3)) begin errors++; $display("FAIL rstmid_busy cyc=%0d got=%b", cyc, o_busy); end
            checks++; if (o_winner_idx !== 4'd0) begin errors++; $display("FAIL rstmid_idx cyc=%0d got=%0d exp=0", cyc, o_winner_idx); end
        end
        i_rst_n = 1'b1;
    endtask

    // Retrigger at 5 reloads the counter: window ends at 13, timeout at 14.
    task automatic test_retrigger();
        for (int c = 0; c < 16; c++) begin
            int cyc;
            i_spike_in = (c == 0 || c == 5);
            i_spike    = '0;
            tick();
            cyc = c + 1;
            checks++; if (o_timeout !== (cyc == 14)) begin errors++; $display("FAIL retrig_timeout cyc=%0d got=%b", cyc, o_timeout); end
            checks++; if (o_busy !== (cyc <= 13)) begin errors++; $display("FAIL retrig_busy cyc=%0d got=%b", cyc, o_busy); end
        end
    endtask

    // Event on the final window cycle (counter at 0) wins instead of timing out.
    task automatic test_last_cycle();
        for (int c = 0; c < 14; c++) begin
            int cyc;
            i_spike_in = (c == 0);
            i_spike    = (c == 8) ? 10'h001 : 10'h000;
            tick();
            cyc = c + 1;
            checks++; if (o_valid !== (cyc == 9)) begin errors++; $display("FAIL last_valid cyc=%0d got=%b", cyc, o_valid); end
            checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL last_timeout cyc=%0d got=%b", cyc, o_timeout); end
            checks++; if (o_winner_idx !== ((cyc >= 9) ? 4'd1 : 4'd0)) begin errors++; $display("FAIL last_idx cyc=%0d got=%0d", cyc, o_winner_idx); end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 16; c++) begin
            int cyc;
            logic [3:0] e_idx;
            logic       e_busy;
            i_spike_in = (c == 0 || c == 6);
            i_spike    = (c == 3) ? 10'h040 : (c == 9) ? 10'h010 : 10'h000;
            tick();
            cyc    = c + 1;
            e_idx  = (cyc < 4) ? 4'd1 : (cyc < 10 || REF) ? 4'd7 : 4'd5;
            e_busy = (cyc <= 3) || (REF ? (cyc >= 4 && cyc <= 7) : (cyc >= 7 && cyc <= 9));
            checks++; if (o_valid !== (cyc == 4 || (!REF && cyc == 10))) begin errors++; $display("FAIL b2b_valid cyc=%0d got=%b", cyc, o_valid); end
            checks++; if (o_winner_idx !== e_idx) begin errors++; $display("FAIL b2b_idx cyc=%0d got=%0d exp=%0d", cyc, o_winner_idx, e_idx); end
            checks++; if (o_busy !== e_busy) begin errors++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, o_busy, e_busy); end
        end
    endtask

    // Trigger and event in the same armed cycle.
    task automatic test_simultaneous();
        for (int c = 0; c < 14; c++) begin
            int cyc;
            logic [3:0] e_idx;
            i_spike_in = (c == 0 || c == 2);
            i_spike    = (c == 2) ? 10'h004 : 10'h000;
            tick();
            cyc   = c + 1;
            e_idx = (cyc < 3) ? (REF ? 4'd7 : 4'd5) : (!REF && cyc >= 11) ? 4'd0 : 4'd3;
            checks++; if (o_valid !== (cyc == 3)) begin errors++; $display("FAIL simul_valid cyc=%0d got=%b", cyc, o_valid); end
            checks++; if (o_timeout !== (!REF && cyc == 11)) begin errors++; $display("FAIL simul_timeout cyc=%0d got=%b", cyc, o_timeout); end
            checks++; if (o_busy !== (REF ? (cyc <= 6) : (cyc <= 10))) begin errors++; $display("FAIL simul_busy cyc=%0d got=%b", cyc, o_busy); end
            checks++; if (o_winner_idx !== e_idx) begin errors++; $display("FAIL simul_idx cyc=%0d got=%0d exp=%0d", cyc, o_winner_idx, e_idx); end
        end
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_spike_in = 1'b0;
        i_spike    = '0;
        test_reset();
        test_single_win();
        idle(4);
        test_double_event();
        test_priority();
        test_timeout();
        idle(2);
        test_reset_mid();
        idle(2);
        test_retrigger();
        idle(2);
        test_last_cycle();
        idle(2);
        test_back_to_back();
        idle(2);
        test_simultaneous();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
